// File: rtl/victory_pkg.sv
// Shared types and constants for the tug-of-war scoreboard: FSM states,
// winner codes and active-low 7-segment digit patterns.
package victory_pkg;

   typedef enum logic [1:0] {
      PLAY = 2'd0,
      RES  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_R    = 2'b01;
   localparam logic [1:0] WIN_L    = 2'b10;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seg7_digit.sv
// Decimal digit to active-low 7-segment decoder; values above 9 blank the digit.
module seg7_digit
   import victory_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (value)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/victory_scoreboard.sv
// Round/match scoreboard for the two-player tug-of-war: credits points,
// stretches the round-restart pulse, gates on full release and latches the winner.
//
// state | meaning
// PLAY  | armed; a lone press at the lit end LED scores a point
// RES   | res high, counting down the restart pulse; inputs ignored
// WAIT  | res low; holds until LEDs and keys are all released
// DONE  | match over; scores frozen until reset
module victory_scoreboard
   import victory_pkg::*;
#(
   parameter int SCORE_W    = 4,
   parameter int WIN_SCORE  = 7,
   parameter int RES_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       LED9,
   input  logic       LED1,
   input  logic       L,
   input  logic       R,
   output logic [6:0] HEX0,
   output logic [6:0] HEX5,
   output logic       res,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam int CNT_W = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(RES_CYCLES - 1);
   localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

   generate
      if (WIN_SCORE > 9 || WIN_SCORE < 1) begin : g_bad_win
         $fatal(1, "victory_scoreboard: WIN_SCORE must be 1..9");
      end
      if ((2 ** SCORE_W) <= WIN_SCORE) begin : g_bad_width
         $fatal(1, "victory_scoreboard: SCORE_W too narrow for WIN_SCORE");
      end
      if (RES_CYCLES < 1) begin : g_bad_res
         $fatal(1, "victory_scoreboard: RES_CYCLES must be >= 1");
      end
   endgenerate

   state_t             state;
   logic [SCORE_W-1:0] score_r;
   logic [SCORE_W-1:0] score_l;
   logic [CNT_W-1:0]   cnt;
   logic               pt_r;
   logic               pt_l;
   logic               any_active;

   assign pt_r       = LED1 & R & ~L;
   assign pt_l       = LED9 & L & ~R;
   assign any_active = LED9 | LED1 | L | R;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= PLAY;
         score_r   <= '0;
         score_l   <= '0;
         cnt       <= '0;
         res       <= 1'b0;
         game_over <= 1'b0;
         winner    <= WIN_NONE;
      end else begin
         case (state)
            PLAY: begin
               if (pt_r) begin
                  score_r <= score_r + SCORE_W'(1);
                  res     <= 1'b1;
                  cnt     <= CNT_LOAD;
                  state   <= RES;
               end else if (pt_l) begin
                  score_l <= score_l + SCORE_W'(1);
                  res     <= 1'b1;
                  cnt     <= CNT_LOAD;
                  state   <= RES;
               end
            end
            RES: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  // Scores were already bumped on entry, so the win check sees the new value.
                  res <= 1'b0;
                  if (score_r == WIN_VAL) begin
                     state     <= DONE;
                     game_over <= 1'b1;
                     winner    <= WIN_R;
                  end else if (score_l == WIN_VAL) begin
                     state     <= DONE;
                     game_over <= 1'b1;
                     winner    <= WIN_L;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!any_active) state <= PLAY;
            end
            DONE: ;
            default: state <= PLAY;
         endcase
      end
   end

   logic [3:0] digit_r;
   logic [3:0] digit_l;

   assign digit_r = (32'(score_r) > 9) ? 4'hF : 4'(score_r);
   assign digit_l = (32'(score_l) > 9) ? 4'hF : 4'(score_l);

   seg7_digit u_hex_r (.value(digit_r), .seg(HEX0));
   seg7_digit u_hex_l (.value(digit_l), .seg(HEX5));

endmodule

// File: tb/tb_victory_scoreboard.sv
// Scoreboard bench: two scoreboard configurations share one stimulus stream and
// are each checked against an independent game-rule model.
module tb_victory_scoreboard;

   typedef struct packed {
      logic [6:0] h0;
      logic [6:0] h5;
      logic       res;
      logic       go;
      logic [1:0] win;
   } obs_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic led9 = 1'b0, led1 = 1'b0, kl = 1'b0, kr = 1'b0;

   logic [6:0] a_hex0, a_hex5, b_hex0, b_hex5;
   logic       a_res, a_go, b_res, b_go;
   logic [1:0] a_win, b_win;

   always #5 clk = ~clk;

   victory_scoreboard #(.SCORE_W(4), .WIN_SCORE(3), .RES_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .LED9(led9), .LED1(led1), .L(kl), .R(kr),
      .HEX0(a_hex0), .HEX5(a_hex5), .res(a_res), .game_over(a_go), .winner(a_win)
   );

   victory_scoreboard #(.SCORE_W(4), .WIN_SCORE(9), .RES_CYCLES(1)) dut_b (
      .clk(clk), .reset(reset), .LED9(led9), .LED1(led1), .L(kl), .R(kr),
      .HEX0(b_hex0), .HEX5(b_hex5), .res(b_res), .game_over(b_go), .winner(b_win)
   );

   // Reference model: per configuration, the game as the rules describe it.
   int m_win[2]  = '{3, 9};
   int m_rc[2]   = '{2, 1};
   int m_sr[2], m_sl[2], m_res_left[2];
   bit m_waiting[2], m_done[2];
   int m_winner[2];

   obs_t qa[$];
   obs_t qb[$];
   int errors = 0;
   int checks = 0;
   int cycle = 0;

   function automatic logic [6:0] seg_of(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic obs_t model_step(input int i);
      obs_t o;
      if (!reset) begin
         m_sr[i] = 0; m_sl[i] = 0; m_res_left[i] = 0;
         m_waiting[i] = 0; m_done[i] = 0; m_winner[i] = 0;
      end else if (m_done[i]) begin
         // frozen
      end else if (m_res_left[i] > 0) begin
         m_res_left[i]--;
         if (m_res_left[i] == 0) begin
            if (m_sr[i] == m_win[i]) begin m_done[i] = 1; m_winner[i] = 1; end
            else if (m_sl[i] == m_win[i]) begin m_done[i] = 1; m_winner[i] = 2; end
            else m_waiting[i] = 1;
         end
      end else if (m_waiting[i]) begin
         if (!(led9 || led1 || kl || kr)) m_waiting[i] = 0;
      end else if (led1 && kr && !kl) begin
         m_sr[i]++; m_res_left[i] = m_rc[i];
      end else if (led9 && kl && !kr) begin
         m_sl[i]++; m_res_left[i] = m_rc[i];
      end
      o.h0  = seg_of(m_sr[i]);
      o.h5  = seg_of(m_sl[i]);
      o.res = (m_res_left[i] > 0);
      o.go  = m_done[i];
      o.win = 2'(m_winner[i]);
      return o;
   endfunction

   task automatic cyc(input bit rst_n, input bit l9, input bit l1, input bit k_l, input bit k_r);
      @(negedge clk);
      reset = rst_n; led9 = l9; led1 = l1; kl = k_l; kr = k_r;
      @(posedge clk);
      qa.push_back(model_step(0));
      qb.push_back(model_step(1));
   endtask

   task automatic hold(input int n, input bit l9, input bit l1, input bit k_l, input bit k_r);
      for (int k = 0; k < n; k++) cyc(1'b1, l9, l1, k_l, k_r);
   endtask

   // Monitor: compares every presented output against the queued expectation.
   initial begin
      obs_t e, g;
      forever begin
         @(negedge clk);
         cycle++;
         if (qa.size() > 0) begin
            e = qa.pop_front();
            g = '{a_hex0, a_hex5, a_res, a_go, a_win};
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL cfgA cycle %0d: got hex0=%b hex5=%b res=%b go=%b win=%b, expected hex0=%b hex5=%b res=%b go=%b win=%b",
                        cycle, g.h0, g.h5, g.res, g.go, g.win, e.h0, e.h5, e.res, e.go, e.win);
            end
         end
         if (qb.size() > 0) begin
            e = qb.pop_front();
            g = '{b_hex0, b_hex5, b_res, b_go, b_win};
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL cfgB cycle %0d: got hex0=%b hex5=%b res=%b go=%b win=%b, expected hex0=%b hex5=%b res=%b go=%b win=%b",
                        cycle, g.h0, g.h5, g.res, g.go, g.win, e.h0, e.h5, e.res, e.go, e.win);
            end
         end
      end
   end

   initial begin
      // reset and idle
      cyc(1'b0, 0, 0, 0, 0);
      hold(2, 0, 0, 0, 0);
      // right point held, then release
      hold(5, 0, 1, 0, 1);
      hold(2, 0, 0, 0, 0);
      // simultaneous press at the left end: no point
      hold(3, 1, 0, 1, 1);
      hold(1, 0, 0, 0, 0);
      // left scores three clean rounds (config A wins)
      for (int r = 0; r < 3; r++) begin
         hold(4, 1, 0, 1, 0);
         hold(2, 0, 0, 0, 0);
      end
      // further points after match end
      hold(3, 0, 1, 0, 1);
      hold(1, 0, 0, 0, 0);
      hold(3, 1, 0, 1, 0);
      hold(1, 0, 0, 0, 0);
      // reset while res is high
      cyc(1'b0, 0, 0, 0, 0);
      hold(1, 0, 1, 0, 1);
      cyc(1'b0, 0, 1, 0, 1);
      hold(2, 0, 0, 0, 0);
      // nine clean right rounds (both configurations reach their targets)
      cyc(1'b0, 0, 0, 0, 0);
      for (int r = 0; r < 9; r++) begin
         hold(3, 0, 1, 0, 1);
         hold(1, 0, 0, 0, 0);
      end
      hold(3, 1, 0, 1, 0);
      // randomized play with occasional resets
      for (int n = 0; n < 3000; n++) begin
         bit rb;
         rb = ($urandom_range(0, 149) != 0);
         cyc(rb, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0));
         if ($urandom_range(0, 3) == 0) hold(int'($urandom_range(1, 3)), 0, 0, 0, 0);
      end
      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) begin
         @(negedge clk);
         #1;
      end
      if (qa.size() > 0 || qb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d/%0d expectations left, required 0", qa.size(), qb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/victory_scoreboard.md
Name: victory_scoreboard

Overview:
- Parametrised round/match scoreboard for the two-player tug-of-war game.
- Detects a point when the light reaches an end LED and that side's player presses alone, then credits the scorer.
- Issues a stretched round-restart pulse to the playfield and waits for a clean release before re-arming; the release gate ensures one point per press.
- Declares a match winner at a programmable target score, drives both score digits on 7-segment displays, and freezes after match end.

Parameters:
- SCORE_W, 4, width of each score counter; must satisfy 2**SCORE_W > WIN_SCORE.
- WIN_SCORE, 7, points needed to win the match; legal range 1..9 (single decimal digit).
- RES_CYCLES, 4, number of cycles res stays high per point; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- LED9  input  1  leftmost playfield LED lit (left/computer end).
- LED1  input  1  rightmost playfield LED lit (right/player end).
- L  input  1  left key, already synchronised and one level per cycle.
- R  input  1  right key, already synchronised.
- HEX0  output  7  right-player score digit, active-low segments.
- HEX5  output  7  left-player score digit, active-low segments.
- res  output  1  round-restart pulse to the playfield.
- game_over  output  1  high once either score reaches WIN_SCORE.
- winner  output  2  00 none, 01 right player, 10 left player.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (reset==0 at posedge): score_r=0, score_l=0, state=PLAY, res=0, game_over=0, winner=00, RES counter=0. HEX0/HEX5 show "0" after the edge. Reset mid-round or during DONE behaves identically.
- Point conditions are combinational:
  - pt_r = LED1 & R & ~L.
  - pt_l = LED9 & L & ~R.
  - The two are mutually exclusive by construction.
- State PLAY:
  - pt_r at edge k: score_r += 1 at edge k; res=1 from edge k; counter loaded with RES_CYCLES-1; go to RES.
  - pt_l at edge k: same, but score_l is incremented.
  - Neither condition: hold all state; res=0.
- State RES:
  - res=1.
  - If counter != 0, decrement the counter and stay in RES.
  - If counter == 0, deassert res at the next edge and go to DONE when either score == WIN_SCORE, otherwise to WAIT.
  - res is high for exactly RES_CYCLES consecutive cycles per point.
  - Inputs are ignored in RES; no scoring.
- State WAIT:
  - res=0.
  - Stay while any of LED9, LED1, L or R is 1.
  - Go to PLAY on the first cycle all four are 0.
  - No scoring in WAIT.
- State DONE:
  - game_over=1; winner is set to the side that reached WIN_SCORE.
  - Scores frozen, res=0, all inputs ignored; exit only via reset.
  - game_over and winner are registered and assert on the same edge DONE is entered.
- Arithmetic:
  - Scores are unsigned SCORE_W-bit values.
  - An increment never exceeds WIN_SCORE, because DONE is reached before any further scoring.
- Display:
  - HEX digits are a combinational decode of the score registers: 0..9 as standard digits, >9 blank (7'b1111111).
  - Segment encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Holding a key with the end LED lit scores once only: the RES and WAIT states block repeats until full release.
- Elaboration checks: fatal error if WIN_SCORE>9, if 2**SCORE_W<=WIN_SCORE, or if RES_CYCLES<1.

Decomposition:
- Package victory_pkg holds:
  - state enum {PLAY, RES, WAIT, DONE};
  - winner constants WIN_NONE=2'b00, WIN_R=2'b01, WIN_L=2'b10;
  - SEG_BLANK and the ten digit segment constants.
- One sub-module: seg7_digit (4-bit value in, 7-bit active-low segments out, blank above 9), instantiated twice.
- FSM and counters stay in victory_scoreboard.

Test Plan (WIN_SCORE=3, RES_CYCLES=2 unless noted):
- Reset: reset=0 for one edge, then 1, all inputs 0 -> HEX0=HEX5=1000000, res=0, game_over=0, winner=00.
- Right point: LED1=1, R=1, L=0 held 5 cycles -> score_r=1 (HEX0=1111001); res high exactly 2 cycles; no second increment while held; state stays WAIT until LED1=R=0, then PLAY.
- Simultaneous press: LED9=1, L=1, R=1 -> no point; scores unchanged; res=0.
- Match win: left scores three clean rounds -> HEX5 goes 1→2→3 (0110000); after the third res pulse, game_over=1 and winner=10; further pt_r/pt_l leave scores frozen.
- Reset mid-RES: reset=0 while res=1 -> next edge res=0, both scores 0, state PLAY.
- Parametric: WIN_SCORE=9, SCORE_W=4, RES_CYCLES=1 -> nine right points give HEX0=0010000, a 1-cycle res per point, and winner=01.
